// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes and the register-master FSM states.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } state_t;

    // States in which the master is waiting on the bus and the timeout counter runs.
    function automatic logic is_wait_state(state_t s);
        return (s == WR_REQ) || (s == WR_RESP) || (s == RD_REQ) || (s == RD_RESP);
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite bus bundle (AW, W, B, AR, R channels) with master and slave views.
interface axi_lite_if #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 32,
    parameter int ID_SIZE   = 32
);
    logic                   awvalid;
    logic                   awready;
    logic [ADDR_SIZE-1:0]   awaddr;
    logic [ID_SIZE-1:0]     awid;

    logic                   wvalid;
    logic                   wready;
    logic [DATA_SIZE-1:0]   wdata;
    logic [DATA_SIZE/8-1:0] wstrb;

    logic                   bvalid;
    logic                   bready;
    logic [ID_SIZE-1:0]     bid;
    logic [1:0]             bresp;

    logic                   arvalid;
    logic                   arready;
    logic [ADDR_SIZE-1:0]   araddr;
    logic [ID_SIZE-1:0]     arid;

    logic                   rvalid;
    logic                   rready;
    logic [DATA_SIZE-1:0]   rdata;
    logic [ID_SIZE-1:0]     rid;
    logic [1:0]             rresp;
    logic                   rlast;

    modport master (
        output awvalid, awaddr, awid, input  awready,
        output wvalid, wdata, wstrb,  input  wready,
        input  bvalid, bid, bresp,    output bready,
        output arvalid, araddr, arid, input  arready,
        input  rvalid, rdata, rid, rresp, rlast, output rready
    );

    modport slave (
        input  awvalid, awaddr, awid, output awready,
        input  wvalid, wdata, wstrb,  output wready,
        output bvalid, bid, bresp,    input  bready,
        input  arvalid, araddr, arid, output arready,
        output rvalid, rdata, rid, rresp, rlast, input rready
    );

endinterface

// File: rtl/axi_lite_timeout_cnt.sv
// Wait counter: cleared on state entry, counts while enabled, flags the last allowed cycle.
module axi_lite_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int              CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Count cycles spent waiting; saturate at the limit so it never wraps.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/axi_lite_reg_master.sv
// Single-outstanding AXI-Lite register master: turns one command into one bus
// transaction and returns one response; all outputs come straight from flops.
module axi_lite_reg_master
    import axi_lite_pkg::*;
#(
    parameter int DATA_SIZE      = 32,
    parameter int ADDR_SIZE      = 32,
    parameter int ID_SIZE        = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,

    input  logic                 cmd_valid,
    input  logic                 cmd_write,
    input  logic [ADDR_SIZE-1:0] cmd_addr,
    input  logic [DATA_SIZE-1:0] cmd_wdata,
    input  logic [ID_SIZE-1:0]   cmd_id,
    output logic                 cmd_ready,

    output logic                 rsp_valid,
    output logic                 rsp_write,
    output logic [DATA_SIZE-1:0] rsp_rdata,
    output logic [1:0]           rsp_resp,
    output logic [ID_SIZE-1:0]   rsp_id,
    output logic                 rsp_timeout,
    input  logic                 rsp_ready,

    axi_lite_if.master           bus
);
    state_t state, state_d;

    logic                   awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic                   awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
    logic [ADDR_SIZE-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [ID_SIZE-1:0]     awid_q, awid_d, arid_q, arid_d;
    logic [DATA_SIZE-1:0]   wdata_q, wdata_d;
    logic [DATA_SIZE/8-1:0] wstrb_q, wstrb_d;

    logic                   cmd_ready_d, rsp_valid_d, rsp_write_d, rsp_timeout_d;
    logic [DATA_SIZE-1:0]   rsp_rdata_d;
    logic [1:0]             rsp_resp_d;
    logic [ID_SIZE-1:0]     rsp_id_d;

    logic                   expired, timed_out;

    axi_lite_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state_d != state),
        .enable  (is_wait_state(state)),
        .expired (expired)
    );

    // Next state and next register values for every output.
    // NOTE: everything starts from a hold-value default so no path can infer a latch.
    always_comb begin
        state_d       = state;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        awaddr_d      = awaddr_q;
        awid_d        = awid_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        araddr_d      = araddr_q;
        arid_d        = arid_q;
        rsp_valid_d   = rsp_valid;
        rsp_write_d   = rsp_write;
        rsp_rdata_d   = rsp_rdata;
        rsp_resp_d    = rsp_resp;
        rsp_id_d      = rsp_id;
        rsp_timeout_d = rsp_timeout;
        timed_out     = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    rsp_write_d   = cmd_write;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b0;
                    if (cmd_addr[1:0] != 2'b00) begin
                        // Misaligned: answer locally, never touch the bus.
                        state_d     = RSP;
                        rsp_valid_d = 1'b1;
                        rsp_resp_d  = RESP_SLVERR;
                        rsp_id_d    = cmd_id;
                    end else if (cmd_write) begin
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = cmd_addr;
                        awid_d    = cmd_id;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = '1;
                    end else begin
                        state_d   = RD_REQ;
                        arvalid_d = 1'b1;
                        araddr_d  = cmd_addr;
                        arid_d    = cmd_id;
                    end
                end
            end
            WR_REQ: begin
                // AW and W retire independently; move on once both are gone.
                if (awvalid_q && bus.awready) awvalid_d = 1'b0;
                if (wvalid_q && bus.wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end else if (expired) begin
                    timed_out = 1'b1;
                end
            end
            WR_RESP: begin
                if (bready_q && bus.bvalid) begin
                    state_d     = RSP;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = bus.bresp;
                    rsp_id_d    = bus.bid;
                end else if (expired) begin
                    timed_out = 1'b1;
                end
            end
            RD_REQ: begin
                if (arvalid_q && bus.arready) begin
                    state_d   = RD_RESP;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end else if (expired) begin
                    timed_out = 1'b1;
                end
            end
            RD_RESP: begin
                // rlast carries no meaning for single-beat AXI-Lite reads.
                if (rready_q && bus.rvalid) begin
                    state_d     = RSP;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = bus.rdata;
                    rsp_resp_d  = bus.rresp;
                    rsp_id_d    = bus.rid;
                end else if (expired) begin
                    timed_out = 1'b1;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A handshake in the expiry cycle already took the branch above, so it wins.
        if (timed_out) begin
            state_d       = RSP;
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_resp_d    = RESP_SLVERR;
            rsp_timeout_d = 1'b1;
            rsp_id_d      = rsp_write ? awid_q : arid_q;
        end

        // Ready only after a full cycle in IDLE, so it rises one clock after reset or a response.
        cmd_ready_d = (state == IDLE) && (state_d == IDLE);
    end

    // State and output registers; reset abandons any transaction in flight.
    // NOTE: every output flop is reset so the bus is quiet the moment reset_n falls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cmd_ready   <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= '0;
            awid_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            araddr_q    <= '0;
            arid_q      <= '0;
            rsp_valid   <= 1'b0;
            rsp_write   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= '0;
            rsp_id      <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_d;
            cmd_ready   <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awaddr_q    <= awaddr_d;
            awid_q      <= awid_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            araddr_q    <= araddr_d;
            arid_q      <= arid_d;
            rsp_valid   <= rsp_valid_d;
            rsp_write   <= rsp_write_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_resp    <= rsp_resp_d;
            rsp_id      <= rsp_id_d;
            rsp_timeout <= rsp_timeout_d;
        end
    end

    assign bus.awvalid = awvalid_q;
    assign bus.awaddr  = awaddr_q;
    assign bus.awid    = awid_q;
    assign bus.wvalid  = wvalid_q;
    assign bus.wdata   = wdata_q;
    assign bus.wstrb   = wstrb_q;
    assign bus.bready  = bready_q;
    assign bus.arvalid = arvalid_q;
    assign bus.araddr  = araddr_q;
    assign bus.arid    = arid_q;
    assign bus.rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_reg_master.sv
// Directed bench for axi_lite_reg_master with a small configurable AXI-Lite slave.
module tb_axi_lite_reg_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0, cmd_id = '0;
    logic        cmd_ready;
    logic        rsp_valid, rsp_write, rsp_timeout;
    logic [31:0] rsp_rdata, rsp_id;
    logic [1:0]  rsp_resp;
    logic        rsp_ready = 1'b0;

    axi_lite_if #(.DATA_SIZE(32), .ADDR_SIZE(32), .ID_SIZE(32)) bus ();

    axi_lite_reg_master #(
        .DATA_SIZE(32), .ADDR_SIZE(32), .ID_SIZE(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_id(cmd_id), .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_id(rsp_id), .rsp_timeout(rsp_timeout),
        .rsp_ready(rsp_ready),
        .bus(bus)
    );

    initial forever #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Slave knobs and observations.
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    bit          b_en = 1, r_en = 1;
    logic [1:0]  bresp_val = 2'b00, rresp_val = 2'b00;
    logic [31:0] rdata_val = '0, bid_val = '0, rid_val = '0;
    int          aw_hs_cnt, w_hs_cnt, b_hs_cnt, ar_hs_cnt, r_hs_cnt;
    int          awvalid_cycles, arvalid_cycles, rready_cycles, ar_changes, rsp_valid_cycles;
    int          aw_hs_cyc, w_hs_cyc;
    logic [31:0] hs_awaddr, hs_wdata, hs_awid, hs_araddr, hs_arid, last_araddr;
    logic [3:0]  hs_wstrb;
    int          aw_k, w_k, ar_k;
    bit          aw_done, w_done, ar_done, aw_hs, w_hs, b_hs, ar_hs, r_hs;

    task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clear_stats();
        aw_hs_cnt = 0; w_hs_cnt = 0; b_hs_cnt = 0; ar_hs_cnt = 0; r_hs_cnt = 0;
        awvalid_cycles = 0; arvalid_cycles = 0; rready_cycles = 0; ar_changes = 0;
        rsp_valid_cycles = 0; aw_hs_cyc = 0; w_hs_cyc = 0;
    endtask

    // Slave model: drives on the falling edge, records handshakes seen at the rising edge.
    initial begin
        bus.awready = 0; bus.wready = 0; bus.arready = 0;
        bus.bvalid = 0; bus.bid = '0; bus.bresp = '0;
        bus.rvalid = 0; bus.rdata = '0; bus.rid = '0; bus.rresp = '0; bus.rlast = 0;
        aw_k = 0; w_k = 0; ar_k = 0;
        {aw_done, w_done, ar_done, aw_hs, w_hs, b_hs, ar_hs, r_hs} = '0;
        clear_stats();
        forever begin
            @(negedge clk);
            if (rsp_valid) rsp_valid_cycles++;
            if (!reset_n) begin
                bus.awready = 0; bus.wready = 0; bus.arready = 0;
                bus.bvalid = 0; bus.rvalid = 0;
                aw_k = 0; w_k = 0; ar_k = 0;
                {aw_done, w_done, ar_done, aw_hs, w_hs, b_hs, ar_hs, r_hs} = '0;
            end else begin
                if (aw_hs) begin aw_done = 1; aw_hs_cnt++; aw_hs_cyc = cyc; end
                if (w_hs)  begin w_done = 1;  w_hs_cnt++;  w_hs_cyc = cyc;  end
                if (b_hs)  begin b_hs_cnt++;  bus.bvalid = 0; end
                if (ar_hs) begin ar_done = 1; ar_hs_cnt++; end
                if (r_hs)  begin r_hs_cnt++;  bus.rvalid = 0; end

                if (bus.awvalid) begin
                    awvalid_cycles++; bus.awready = (aw_k >= aw_delay); aw_k++;
                end else begin
                    bus.awready = 0; aw_k = 0;
                end
                if (bus.wvalid) begin
                    bus.wready = (w_k >= w_delay); w_k++;
                end else begin
                    bus.wready = 0; w_k = 0;
                end
                if (bus.arvalid) begin
                    arvalid_cycles++;
                    if (ar_k > 0 && bus.araddr !== last_araddr) ar_changes++;
                    last_araddr = bus.araddr;
                    bus.arready = (ar_k >= ar_delay); ar_k++;
                end else begin
                    bus.arready = 0; ar_k = 0;
                end
                if (bus.rready) rready_cycles++;

                if (aw_done && w_done && b_en && !bus.bvalid) begin
                    bus.bvalid = 1; bus.bresp = bresp_val; bus.bid = bid_val;
                    aw_done = 0; w_done = 0;
                end
                if (ar_done && r_en && !bus.rvalid) begin
                    bus.rvalid = 1; bus.rdata = rdata_val; bus.rresp = rresp_val;
                    bus.rid = rid_val; bus.rlast = 1;
                    ar_done = 0;
                end

                aw_hs = bus.awvalid && bus.awready;
                w_hs  = bus.wvalid && bus.wready;
                b_hs  = bus.bvalid && bus.bready;
                ar_hs = bus.arvalid && bus.arready;
                r_hs  = bus.rvalid && bus.rready;
                if (aw_hs) begin hs_awaddr = bus.awaddr; hs_awid = bus.awid; end
                if (w_hs)  begin hs_wdata = bus.wdata; hs_wstrb = bus.wstrb; end
                if (ar_hs) begin hs_araddr = bus.araddr; hs_arid = bus.arid; end
            end
        end
    end

    // Present one command on a falling edge once cmd_ready is up.
    task automatic send_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] id);
        int n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        check("cmd_ready_wait", cmd_ready, 1'b1);
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_id = id;
        @(negedge clk);
        cmd_valid = 0;
    endtask

    // Wait for a response, check it on arrival and after one stalled cycle, then accept it.
    task automatic wait_rsp(input string tag, input bit e_write, input logic [31:0] e_rdata,
                            input logic [1:0] e_resp, input bit use_id, input logic [31:0] e_id,
                            input bit e_timeout);
        int n = 0;
        while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
        check({tag, "_valid"}, rsp_valid, 1'b1);
        check({tag, "_payload"}, {rsp_write, rsp_rdata, rsp_resp, use_id ? rsp_id : 32'h0, rsp_timeout},
              {e_write, e_rdata, e_resp, use_id ? e_id : 32'h0, e_timeout});
        @(negedge clk);
        check({tag, "_hold"}, {rsp_valid, rsp_write, rsp_rdata, rsp_resp, use_id ? rsp_id : 32'h0, rsp_timeout},
              {1'b1, e_write, e_rdata, e_resp, use_id ? e_id : 32'h0, e_timeout});
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        check({tag, "_drop"}, rsp_valid, 1'b0);
    endtask

    int t0, n;

    initial begin
        // Reset values.
        repeat (3) @(negedge clk);
        check("reset_ctrl", {cmd_ready, rsp_valid, bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 7'b0);
        check("reset_payload", {bus.awaddr, bus.wdata, rsp_rdata}, 96'h0);
        reset_n = 1;
        #1 check("cmd_ready_pre_clk", cmd_ready, 1'b0);
        @(negedge clk);
        check("cmd_ready_after_rst", cmd_ready, 1'b1);

        // Aligned write, zero-wait slave.
        clear_stats(); aw_delay = 0; w_delay = 0; b_en = 1; bresp_val = 2'b00; bid_val = 32'h11;
        send_cmd(1, 32'h3004, 32'h1234_5678, 32'h11);
        wait_rsp("wr0", 1, 32'h0, 2'b00, 1, 32'h11, 0);
        check("wr0_same_cycle_hs", aw_hs_cyc - w_hs_cyc, 0);
        check("wr0_aw", {hs_awaddr, hs_awid}, {32'h3004, 32'h11});
        check("wr0_w", {hs_wdata, hs_wstrb}, {32'h1234_5678, 4'hF});
        check("wr0_b_count", b_hs_cnt, 1);

        // Aligned read, arready three cycles late.
        clear_stats(); ar_delay = 3; r_en = 1; rdata_val = 32'hDEAD_BEEF; rresp_val = 2'b00; rid_val = 32'h22;
        send_cmd(0, 32'h4010, 32'h0, 32'h22);
        wait_rsp("rd0", 0, 32'hDEAD_BEEF, 2'b00, 1, 32'h22, 0);
        check("rd0_arvalid_cycles", arvalid_cycles, 4);
        check("rd0_ar_stable", ar_changes, 0);
        check("rd0_ar", {hs_araddr, hs_arid}, {32'h4010, 32'h22});
        ar_delay = 0;

        // Write with W accepted two cycles before AW; SLVERR and a bus-chosen ID come back.
        clear_stats(); aw_delay = 2; w_delay = 0; bresp_val = 2'b10; bid_val = 32'h5A;
        send_cmd(1, 32'h0008, 32'hCAFE_0001, 32'h33);
        wait_rsp("wr1", 1, 32'h0, 2'b10, 1, 32'h5A, 0);
        repeat (3) @(negedge clk);
        check("wr1_w_before_aw", aw_hs_cyc - w_hs_cyc, 2);
        check("wr1_hs_counts", {aw_hs_cnt[7:0], w_hs_cnt[7:0], b_hs_cnt[7:0]}, {8'd1, 8'd1, 8'd1});
        aw_delay = 0; bresp_val = 2'b00;

        // Misaligned read: no bus activity at all.
        clear_stats();
        send_cmd(0, 32'h0002, 32'h0, 32'h44);
        wait_rsp("rd_mis", 0, 32'h0, 2'b10, 0, 32'h0, 0);
        check("rd_mis_no_bus", {arvalid_cycles[15:0], awvalid_cycles[15:0]}, 32'h0);

        // Read timeout: slave never returns data.
        clear_stats(); r_en = 0;
        send_cmd(0, 32'h0020, 32'h0, 32'h55);
        wait_rsp("rd_to", 0, 32'h0, 2'b10, 0, 32'h0, 1);
        check("rd_to_rready_cycles", rready_cycles, 16);
        check("rd_to_rready_low", bus.rready, 1'b0);
        check("rd_to_no_r_hs", r_hs_cnt, 0);
        r_en = 1;

        // Command-to-command spacing with rsp_ready held high.
        clear_stats(); rsp_ready = 1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        t0 = cyc;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h0100; cmd_wdata = 32'h1; cmd_id = 32'h66;
        @(negedge clk);
        cmd_valid = 0;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        check("throughput_cycles", cyc - t0, 5);
        check("throughput_b_count", b_hs_cnt, 1);
        rsp_ready = 0;

        // Reset while waiting for B.
        clear_stats(); b_en = 0;
        send_cmd(1, 32'h0200, 32'hAAAA_5555, 32'h77);
        n = 0;
        while (!bus.bready && n < 20) begin @(negedge clk); n++; end
        check("rst_in_wr_resp", bus.bready, 1'b1);
        #2 reset_n = 0;
        #1 check("rst_async_ctrl", {cmd_ready, rsp_valid, bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 7'b0);
        check("rst_async_payload", {bus.awaddr, bus.wdata, bus.wstrb}, 68'h0);
        repeat (2) @(negedge clk);
        reset_n = 1;
        #1 check("rst_rel_pre_clk", cmd_ready, 1'b0);
        @(negedge clk);
        check("rst_rel_cmd_ready", cmd_ready, 1'b1);
        b_en = 1;
        repeat (6) @(negedge clk);
        check("rst_no_rsp", rsp_valid_cycles, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_lite_reg_master.md
AXI_LITE_REG_MASTER -- requirements
Module: axi_lite_reg_master

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32: AXI-Lite data width in bits.
REQ-002 SHALL have parameter ADDR_SIZE, default 32: AXI-Lite address width in bits.
REQ-003 SHALL have parameter ID_SIZE, default 32: width of the transaction ID.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024: cycle limit for any single bus wait.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have command inputs cmd_valid (1), cmd_write (1), cmd_addr (ADDR_SIZE), cmd_wdata (DATA_SIZE) and cmd_id (ID_SIZE), and output cmd_ready (1).
REQ-008 SHALL have response outputs rsp_valid (1), rsp_write (1), rsp_rdata (DATA_SIZE), rsp_resp (2), rsp_id (ID_SIZE) and rsp_timeout (1), and input rsp_ready (1).
REQ-009 SHALL have AW channel outputs awvalid, awaddr and awid, and input awready.
REQ-010 SHALL have W channel outputs wvalid, wdata and wstrb (DATA_SIZE/8 bits), and input wready.
REQ-011 SHALL have B channel inputs bvalid, bid and bresp, and output bready.
REQ-012 SHALL have AR channel outputs arvalid, araddr and arid, and input arready.
REQ-013 SHALL have R channel inputs rvalid, rdata, rid, rresp and rlast, and output rready.

Function
REQ-014 SHALL drive all outputs from registers.
REQ-015 SHALL use FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP and RSP.
REQ-016 SHALL assert cmd_ready only in IDLE, and accept a command on the cycle cmd_valid && cmd_ready.
REQ-017 SHALL allow only one outstanding transaction at a time.
REQ-018 SHALL go from IDLE to RSP without any bus activity when an accepted command has cmd_addr[1:0] != 0, returning rsp_resp=2'b10 and rsp_timeout=0.
REQ-019 SHALL go from IDLE to WR_REQ on an aligned write, asserting awvalid and wvalid together on the cycle after acceptance, with wstrb all ones and awid=cmd_id.
REQ-020 SHALL, in WR_REQ, drop awvalid on the awvalid && awready cycle and drop wvalid on the wvalid && wready cycle, each independently; when both are done (same cycle or different cycles) it SHALL move to WR_RESP.
REQ-021 SHALL, in WR_RESP, assert bready; on bvalid && bready it SHALL capture bresp and bid, deassert bready and move to RSP.
REQ-022 SHALL go from IDLE to RD_REQ on an aligned read, asserting arvalid on the next cycle with arid=cmd_id; on arvalid && arready it SHALL drop arvalid and move to RD_RESP.
REQ-023 SHALL, in RD_RESP, assert rready; on rvalid && rready it SHALL capture rdata, rresp and rid, then move to RSP; rlast SHALL be ignored.
REQ-024 SHALL, in RSP, hold rsp_valid=1 with stable payload until rsp_ready, then return to IDLE.
REQ-025 SHALL set rsp_rdata=0 for writes, and SHALL report rsp_id as the bus-returned ID.
REQ-026 SHALL hold awvalid, wvalid and arvalid, with stable payload, until their handshakes complete; they SHALL never depend combinationally on any ready.
REQ-027 SHALL clear a wait counter on every state entry and increment it in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
REQ-028 SHALL, when the wait counter reaches TIMEOUT_CYCLES-1, deassert all valids and readies, set rsp_resp=2'b10 and rsp_timeout=1, and move to RSP.
REQ-029 SHALL, when a handshake and a timeout occur in the same cycle, let the handshake win.
REQ-030 SHALL, from IDLE with rsp_ready already high, make the earliest command-to-command throughput one command per 5 cycles for a zero-wait slave.

Reset
REQ-031 SHALL, while reset_n=0, go to IDLE with all valid and ready outputs 0, cmd_ready=0, all payload outputs 0 and the wait counter 0; cmd_ready SHALL rise on the first clock after release.
REQ-032 SHALL, when reset is asserted mid-transaction, abandon the transaction immediately and produce no response for it.

Structure
REQ-033 SHALL take the response codes (OKAY=2'b00, SLVERR=2'b10) and the FSM state enum from the shared package axi_lite_pkg.
REQ-034 SHALL implement the wait counter as the sub-module axi_lite_timeout_cnt, with inputs clear and enable, parameter TIMEOUT_CYCLES, and an expired output.

Verification
REQ-035 Write 0x1234_5678 to 0x3004, slave ready at once and bresp=00 -> AW/W handshakes on the same cycle, then rsp_valid with rsp_write=1, rsp_resp=00, rsp_timeout=0.
REQ-036 Read 0x4010 with arready delayed 3 cycles and rdata=0xDEAD_BEEF -> arvalid held stable for 4 cycles, then rsp_rdata=0xDEAD_BEEF, rsp_resp=00.
REQ-037 Write with wready 2 cycles before awready -> wvalid drops first, awvalid drops later, exactly one B handshake follows.
REQ-038 Read 0x0002 -> no arvalid ever asserted, then rsp_resp=10 and rsp_timeout=0.
REQ-039 Read with the slave never asserting rvalid and TIMEOUT_CYCLES=16 -> rready drops, then rsp_resp=10 and rsp_timeout=1.
REQ-040 Assert reset_n=0 during WR_RESP -> all outputs 0 asynchronously and no rsp_valid; cmd_ready=1 one cycle after release.
